otter_csr_intr: RTL and testbench
=================================

Name: otter_csr_intr

Overview:
Machine-mode CSR file and external-interrupt front end for the multicycle OTTER core. Consumes the control unit's csr_WE, int_taken and mret_exec strobes. Produces the registered interrupt request that the control unit samples in EXEC/WRITE_BACK, plus the trap vector (mtvec) and return address (mepc) for the PC mux. Sits beside the register file; CSR read data feeds the writeback mux.

Parameters:
MTVEC_RST, 32'h0000_0000, reset value of mtvec
SYNC_STAGES, 2, synchronizer depth on INTR_IN (legal values 2..3)

Ports:
CSR_clk  in  1  core clock
CSR_RST_n  in  1  reset; asynchronous, active-low
CSR_WE  in  1  write strobe from the control unit (csrrw/csrrs/csrrc in EXEC)
INT_TAKEN  in  1  trap-entry strobe (control unit INTR state)
MRET_EXEC  in  1  mret strobe
CSR_ADDR  in  12  instr[31:20]
CSR_WD  in  32  write data, already combined by the ALU for rw/rs/rc
CSR_PC  in  32  PC of the instruction to resume (saved to mepc)
INTR_IN  in  1  asynchronous external interrupt level
CSR_RD  out  32  combinational read data for CSR_ADDR
CSR_MTVEC  out  32  trap vector
CSR_MEPC  out  32  return address
CSR_MIE  out  1  mstatus.MIE
INTR_OUT  out  1  interrupt request to the control unit

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, all other bits read 0.
  - mie 0x304: MEIE bit 11 only.
  - mtvec 0x305: bits [1:0] forced to 0 on write.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342: read/write.
  - mip 0x344: read-only; MEIP bit 11 = pending.
- Unimplemented addresses read 32'h0; writes to them and to mip are silently ignored.
- Reset (CSR_RST_n=0, async): mstatus=0, mie=0, mtvec=MTVEC_RST, mepc=0, mcause=0, pending=0, synchronizer and edge flops=0. Consequently CSR_RD follows address with zeroed regs, INTR_OUT=0, CSR_MIE=0.
- Reset asserted mid-operation clears pending immediately; an interrupt level still high at release is seen as a new rising edge.
- Writes: all updates land on the rising CSR_clk edge while the strobe is high. Read is zero-latency combinational.
- Interrupt path:
  - INTR_IN passes through SYNC_STAGES flops, then an edge flop.
  - rise = sync_out & ~edge_q.
  - pending <= 1 on rise.
  - With SYNC_STAGES=2, a level set before edge 1 makes pending=1 after edge 3.
  - Level-held inputs create exactly one pending event.
- INTR_OUT = pending & mstatus.MIE & mie.MEIE, combinational from registers, no glitch from INTR_IN.
- INT_TAKEN:
  - mepc <= CSR_PC & ~3
  - mcause <= 32'h8000_000B
  - MPIE <= MIE; MIE <= 0
  - pending <= 0, unless rise is true in the same cycle, in which case pending stays 1 (the new event is not lost).
- MRET_EXEC: MIE <= MPIE, MPIE <= 1.
- Priority on mstatus/mepc/mcause when strobes coincide: INT_TAKEN > MRET_EXEC > CSR_WE. The losing write is dropped entirely for that register; writes to other registers in the same cycle proceed.
- No state machine beyond the pending latch. The trap FSM lives in the control unit; this block never stalls.

Decomposition:
- Package otter_csr_pkg holds:
  - CSR address localparams (ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MEPC, ADDR_MCAUSE, ADDR_MIP)
  - bit-position constants (MSTATUS_MIE=3, MSTATUS_MPIE=7, MEIx=11)
  - MCAUSE_MEI = 32'h8000_000B
- One sub-module: otter_intr_sync, containing the parameterised synchronizer, edge flop and rise output, with async active-low reset.

Test Plan:
- Reset release; read 0x300/0x305/0x341 -> 0, 0 (MTVEC_RST), 0; INTR_IN=1 -> INTR_OUT stays 0.
- CSR_WE: 0x305 <= 32'h0000_1003 -> CSR_MTVEC = 32'h0000_1000. Then 0x304 <= 32'h800 and 0x300 <= 32'h8 -> CSR_MIE=1. Then INTR_IN rise -> INTR_OUT=1 after the 3rd edge.
- INT_TAKEN with CSR_PC=32'h0000_0204 -> mepc=32'h204, mcause=32'h8000_000B, mstatus=32'h80, INTR_OUT=0, mip reads 0.
- MRET_EXEC after the trap -> mstatus=32'h88. INTR_IN held high -> no new INTR_OUT. Drop and raise INTR_IN -> INTR_OUT=1 again.
- INT_TAKEN coincident with a fresh rise -> pending=1 and mip reads 32'h800, but INTR_OUT=0 while MIE=0. After MRET -> INTR_OUT=1.
- CSR_WE to 0x300 (value 0) together with MRET_EXEC (MPIE=1) -> mstatus=32'h88 (MRET wins). Write to 0x7C0 -> reads 0. Assert CSR_RST_n=0 mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/otter_csr_pkg.sv
// Shared constants for the OTTER machine-mode CSR file: CSR addresses,
// mstatus/mie/mip bit positions and the external-interrupt mcause code.
package otter_csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MEIx         = 11;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

endpackage

// File: rtl/otter_csr_intr_if.sv
// CSR/interrupt bus between the OTTER control unit (master) and the CSR file (slave).
// Signal names match the core's CSR port names so the datapath wiring reads unchanged.
interface otter_csr_intr_if;
    logic        CSR_WE;
    logic        INT_TAKEN;
    logic        MRET_EXEC;
    logic [11:0] CSR_ADDR;
    logic [31:0] CSR_WD;
    logic [31:0] CSR_PC;
    logic        INTR_IN;
    logic [31:0] CSR_RD;
    logic [31:0] CSR_MTVEC;
    logic [31:0] CSR_MEPC;
    logic        CSR_MIE;
    logic        INTR_OUT;

    modport master (
        output CSR_WE, INT_TAKEN, MRET_EXEC, CSR_ADDR, CSR_WD, CSR_PC, INTR_IN,
        input  CSR_RD, CSR_MTVEC, CSR_MEPC, CSR_MIE, INTR_OUT
    );

    modport slave (
        input  CSR_WE, INT_TAKEN, MRET_EXEC, CSR_ADDR, CSR_WD, CSR_PC, INTR_IN,
        output CSR_RD, CSR_MTVEC, CSR_MEPC, CSR_MIE, INTR_OUT
    );
endinterface

// File: rtl/otter_intr_sync.sv
// External interrupt synchronizer plus rising-edge detector.
// Latency: rise asserts SYNC_STAGES edges after the level is captured; never stalls.
// No backpressure: rise is a one-cycle pulse per low-to-high transition.
module otter_intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic intr_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], intr_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Cleared edge flop after reset makes a level held through reset look like a fresh rise.
    assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/otter_csr_intr.sv
// Machine-mode CSR file and external-interrupt request latch for the multicycle OTTER core.
// Latency: reads combinational, writes/trap updates land on the next CSR_clk edge.
// Never stalls; simultaneous strobes resolve as INT_TAKEN > MRET_EXEC > CSR_WE.
module otter_csr_intr
    import otter_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              CSR_clk,
    input  logic              CSR_RST_n,
    otter_csr_intr_if.slave   bus
);

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        pending;
    logic        rise;

    logic        wr_mstatus;
    logic        wr_mie;
    logic        wr_mtvec;
    logic        wr_mepc;
    logic        wr_mcause;
    logic [31:0] rd_dat;

    otter_intr_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_intr_sync (
        .clk     (CSR_clk),
        .rst_n   (CSR_RST_n),
        .intr_in (bus.INTR_IN),
        .rise    (rise)
    );

    assign wr_mstatus = bus.CSR_WE && (bus.CSR_ADDR == ADDR_MSTATUS);
    assign wr_mie     = bus.CSR_WE && (bus.CSR_ADDR == ADDR_MIE);
    assign wr_mtvec   = bus.CSR_WE && (bus.CSR_ADDR == ADDR_MTVEC);
    assign wr_mepc    = bus.CSR_WE && (bus.CSR_ADDR == ADDR_MEPC);
    assign wr_mcause  = bus.CSR_WE && (bus.CSR_ADDR == ADDR_MCAUSE);

    always_ff @(posedge CSR_clk or negedge CSR_RST_n) begin
        if (!CSR_RST_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (bus.INT_TAKEN) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (bus.MRET_EXEC) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_mstatus) begin
            mstatus_mie  <= bus.CSR_WD[MSTATUS_MIE];
            mstatus_mpie <= bus.CSR_WD[MSTATUS_MPIE];
        end
    end

    // Trap entry owns mepc/mcause; software writes only land when no trap is taken.
    always_ff @(posedge CSR_clk or negedge CSR_RST_n) begin
        if (!CSR_RST_n) begin
            mepc   <= '0;
            mcause <= '0;
        end else if (bus.INT_TAKEN) begin
            mepc   <= bus.CSR_PC & ~32'h3;
            mcause <= MCAUSE_MEI;
        end else begin
            if (wr_mepc)   mepc   <= bus.CSR_WD & ~32'h3;
            if (wr_mcause) mcause <= bus.CSR_WD;
        end
    end

    always_ff @(posedge CSR_clk or negedge CSR_RST_n) begin
        if (!CSR_RST_n) begin
            mie_meie <= 1'b0;
            mtvec    <= MTVEC_RST;
        end else begin
            if (wr_mie)   mie_meie <= bus.CSR_WD[MEIx];
            if (wr_mtvec) mtvec    <= bus.CSR_WD & ~32'h3;
        end
    end

    // A rise in the trap-entry cycle is a new event and must survive the clear.
    always_ff @(posedge CSR_clk or negedge CSR_RST_n) begin
        if (!CSR_RST_n) begin
            pending <= 1'b0;
        end else if (rise) begin
            pending <= 1'b1;
        end else if (bus.INT_TAKEN) begin
            pending <= 1'b0;
        end
    end

    always_comb begin
        rd_dat = '0;
        case (bus.CSR_ADDR)
            ADDR_MSTATUS: begin
                rd_dat[MSTATUS_MIE]  = mstatus_mie;
                rd_dat[MSTATUS_MPIE] = mstatus_mpie;
            end
            ADDR_MIE:    rd_dat[MEIx] = mie_meie;
            ADDR_MTVEC:  rd_dat = mtvec;
            ADDR_MEPC:   rd_dat = mepc;
            ADDR_MCAUSE: rd_dat = mcause;
            ADDR_MIP:    rd_dat[MEIx] = pending;
            default:     rd_dat = '0;
        endcase
    end

    assign bus.CSR_RD    = rd_dat;
    assign bus.CSR_MTVEC = mtvec;
    assign bus.CSR_MEPC  = mepc;
    assign bus.CSR_MIE   = mstatus_mie;
    assign bus.INTR_OUT  = pending & mstatus_mie & mie_meie;

endmodule

// File: tb/tb_otter_csr_intr.sv
// Directed-vector bench for otter_csr_intr: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_otter_csr_intr;

    localparam int SEL_RD    = 0;
    localparam int SEL_MTVEC = 1;
    localparam int SEL_MEPC  = 2;
    localparam int SEL_MIE   = 3;
    localparam int SEL_INTR  = 4;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    otter_csr_intr_if bus ();

    otter_csr_intr #(
        .MTVEC_RST   (32'h0000_0000),
        .SYNC_STAGES (2)
    ) dut (
        .CSR_clk   (clk),
        .CSR_RST_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: consumes every queued expectation at the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() != 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.sel)
                SEL_RD:    act = bus.CSR_RD;
                SEL_MTVEC: act = bus.CSR_MTVEC;
                SEL_MEPC:  act = bus.CSR_MEPC;
                SEL_MIE:   act = {31'b0, bus.CSR_MIE};
                default:   act = {31'b0, bus.INTR_OUT};
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got 32'h%08h, expected 32'h%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL monitor_timeout: %0d expectations unconsumed, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk(input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        sb_q.push_back(e);
        drain();
    endtask

    task automatic chk_rd(input logic [11:0] a, input logic [31:0] v, input string nm);
        bus.CSR_ADDR = a;
        chk(SEL_RD, v, nm);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        bus.CSR_WE   = 1'b1;
        bus.CSR_ADDR = a;
        bus.CSR_WD   = wd;
        @(posedge clk); #1;
        bus.CSR_WE   = 1'b0;
    endtask

    task automatic trap(input logic [31:0] pc);
        @(posedge clk); #1;
        bus.INT_TAKEN = 1'b1;
        bus.CSR_PC    = pc;
        @(posedge clk); #1;
        bus.INT_TAKEN = 1'b0;
    endtask

    task automatic mret();
        @(posedge clk); #1;
        bus.MRET_EXEC = 1'b1;
        @(posedge clk); #1;
        bus.MRET_EXEC = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.CSR_WE    = 1'b0;
        bus.INT_TAKEN = 1'b0;
        bus.MRET_EXEC = 1'b0;
        bus.CSR_ADDR  = 12'h300;
        bus.CSR_WD    = 32'h0;
        bus.CSR_PC    = 32'h0;
        bus.INTR_IN   = 1'b0;

        // Reset state
        chk_rd(12'h300, 32'h0, "rst_mstatus");
        chk(SEL_INTR, 32'h0, "rst_intr_out");
        chk(SEL_MIE, 32'h0, "rst_mie");
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_rd(12'h305, 32'h0, "mtvec_rst");
        chk_rd(12'h341, 32'h0, "mepc_rst");

        // Interrupt with MIE clear: latched but not requested
        bus.INTR_IN = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk(SEL_INTR, 32'h0, "intr_masked");
        chk_rd(12'h344, 32'h0000_0800, "mip_masked_pending");
        bus.INTR_IN = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        chk_rd(12'h344, 32'h0, "mip_cleared_by_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Configuration writes
        csr_write(12'h305, 32'h0000_1003);
        chk(SEL_MTVEC, 32'h0000_1000, "mtvec_out");
        chk_rd(12'h305, 32'h0000_1000, "mtvec_rd");
        csr_write(12'h304, 32'h0000_0800);
        chk_rd(12'h304, 32'h0000_0800, "mie_rd");
        csr_write(12'h300, 32'h0000_0008);
        chk(SEL_MIE, 32'h1, "csr_mie_set");
        chk_rd(12'h300, 32'h0000_0008, "mstatus_rd");
        chk(SEL_INTR, 32'h0, "intr_idle");

        // Rising edge: visible after the third edge
        @(posedge clk); #1;
        bus.INTR_IN = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk(SEL_INTR, 32'h0, "intr_after_edge2");
        @(posedge clk); #1;
        chk(SEL_INTR, 32'h1, "intr_after_edge3");
        chk_rd(12'h344, 32'h0000_0800, "mip_pending");

        // Trap entry
        trap(32'h0000_0207);
        chk(SEL_MEPC, 32'h0000_0204, "mepc_out");
        chk_rd(12'h341, 32'h0000_0204, "mepc_rd");
        chk_rd(12'h342, 32'h8000_000B, "mcause_trap");
        chk_rd(12'h300, 32'h0000_0080, "mstatus_trap");
        chk(SEL_INTR, 32'h0, "intr_after_trap");
        chk_rd(12'h344, 32'h0, "mip_after_trap");
        chk(SEL_MIE, 32'h0, "csr_mie_trap");

        // Return; held level does not retrigger
        mret();
        chk_rd(12'h300, 32'h0000_0088, "mstatus_mret");
        repeat (4) @(posedge clk);
        #1;
        chk(SEL_INTR, 32'h0, "intr_level_held");
        bus.INTR_IN = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.INTR_IN = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk(SEL_INTR, 32'h1, "intr_second_rise");

        // Trap entry coincident with a fresh rise keeps pending
        bus.INTR_IN = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.INTR_IN = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        bus.INT_TAKEN = 1'b1;
        bus.CSR_PC    = 32'h0000_0300;
        @(posedge clk); #1;
        bus.INT_TAKEN = 1'b0;
        chk_rd(12'h344, 32'h0000_0800, "mip_coincident_rise");
        chk(SEL_INTR, 32'h0, "intr_coincident_masked");
        chk_rd(12'h300, 32'h0000_0080, "mstatus_coincident");
        chk(SEL_MEPC, 32'h0000_0300, "mepc_coincident");
        mret();
        chk(SEL_INTR, 32'h1, "intr_after_mret");

        // MRET beats a simultaneous mstatus write
        @(posedge clk); #1;
        bus.CSR_WE    = 1'b1;
        bus.CSR_ADDR  = 12'h300;
        bus.CSR_WD    = 32'h0;
        bus.MRET_EXEC = 1'b1;
        @(posedge clk); #1;
        bus.CSR_WE    = 1'b0;
        bus.MRET_EXEC = 1'b0;
        chk_rd(12'h300, 32'h0000_0088, "mret_beats_we");

        // Unimplemented / read-only / plain read-write registers
        csr_write(12'h7C0, 32'hFFFF_FFFF);
        chk_rd(12'h7C0, 32'h0, "unimpl_rd");
        csr_write(12'h344, 32'h0);
        chk_rd(12'h344, 32'h0000_0800, "mip_write_ignored");
        csr_write(12'h342, 32'h1234_5678);
        chk_rd(12'h342, 32'h1234_5678, "mcause_rw");
        csr_write(12'h341, 32'h0000_1237);
        chk_rd(12'h341, 32'h0000_1234, "mepc_write_mask");

        // Asynchronous reset mid-cycle
        @(posedge clk); #2;
        rst_n = 1'b0;
        chk_rd(12'h341, 32'h0, "async_rst_rd");
        chk(SEL_MEPC, 32'h0, "async_rst_mepc");
        chk(SEL_MTVEC, 32'h0, "async_rst_mtvec");
        chk(SEL_MIE, 32'h0, "async_rst_mie");
        chk(SEL_INTR, 32'h0, "async_rst_intr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
